// File: rtl/four_bit_adder.sv
// ---------------------------------------------------------------------------
// four_bit_adder
//
// Registered WIDTH-bit binary adder with carry-in. This is the arithmetic
// building block for the SAP datapath.
//
// The sum is produced by a structural ripple-carry chain of full adders, each
// built from XOR/AND/OR terms. A behavioural A+B+C is computed alongside it
// from the same inputs. The two results are compared every cycle, so any
// divergence in the gate-level chain shows up on MISMATCH. MISMATCH stays 0 in
// a healthy build. It is a live self-check and must not be tied off.
//
// There is no handshake and no state machine: the block samples its inputs on
// every rising CLK edge and presents the result one cycle later.
//
// Ports:
//   CLK      in   1      rising-edge clock
//   CLR_N    in   1      asynchronous active-low clear of all outputs
//   A        in   WIDTH  operand A, unsigned
//   B        in   WIDTH  operand B, unsigned
//   C        in   1      carry-in
//   SUM      out  WIDTH  registered low WIDTH bits of A+B+C
//   CARRY    out  1      registered carry-out (bit WIDTH of A+B+C)
//   MISMATCH out  1      registered flag, structural != behavioural
// ---------------------------------------------------------------------------
module four_bit_adder #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             MISMATCH
);

  // Ripple chain: carry[0] is the external carry-in, and carry[WIDTH] is the
  // structural carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_struct;
  logic [WIDTH:0]   struct_result;
  logic [WIDTH:0]   beh_result;

  assign carry[0] = C;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;  // propagate term, shared by the sum and the carry
    assign p            = A[i] ^ B[i];
    assign s_struct[i]  = p ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & p);
  end

  assign struct_result = {carry[WIDTH], s_struct};

  // Independent arithmetic path. The operands are zero-extended so the
  // carry-out lands in bit WIDTH.
  assign beh_result = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, C};

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      SUM      <= '0;
      CARRY    <= 1'b0;
      MISMATCH <= 1'b0;
    end else begin
      SUM      <= struct_result[WIDTH-1:0];
      CARRY    <= struct_result[WIDTH];
      MISMATCH <= (struct_result != beh_result);
    end
  end

endmodule

// File: tb/tb_four_bit_adder.sv
// ---------------------------------------------------------------------------
// tb_four_bit_adder
//
// Self-checking bench for four_bit_adder. The inputs are driven on the falling
// clock edge. The outputs are sampled 1 time unit after the rising edge.
//
// Expected results come from plain integer arithmetic (a + b + c) and pass
// through a queue. Each value is pushed when its inputs are driven and popped
// after the edge that registers it.
// ---------------------------------------------------------------------------
module tb_four_bit_adder;
  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         CLR_N;
  logic [W-1:0] A, B;
  logic         C;
  logic [W-1:0] SUM;
  logic         CARRY;
  logic         MISMATCH;

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  four_bit_adder #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .CLR_N    (CLR_N),
    .A        (A),
    .B        (B),
    .C        (C),
    .SUM      (SUM),
    .CARRY    (CARRY),
    .MISMATCH (MISMATCH)
  );

  // ---------------- clock / watchdog ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input int a, input int b, input int c);
    int total;
    logic [W:0] r;
    total = a + b + c;
    r = total[W:0];
    return r;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [W:0] exp);
    check({tag, "_sum"},      8'(SUM),      8'(exp[W-1:0]));
    check({tag, "_carry"},    8'(CARRY),    8'(exp[W]));
    check({tag, "_mismatch"}, 8'(MISMATCH), 8'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int a, input int b, input int c);
    @(negedge CLK);
    A = a[W-1:0];
    B = b[W-1:0];
    C = c[0];
    exp_q.push_back(model(a, b, c));
  endtask

  task automatic tick_and_score(input string tag);
    logic [W:0] e;
    @(posedge CLK);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = exp_q.pop_front();
      check_out(tag, e);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [8:0] v;
    int ra, rb, rc;

    // Reset held with all-ones inputs; outputs stay clear across edges.
    CLR_N = 1'b0;
    A = 4'hF;
    B = 4'hF;
    C = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      check_out("reset_hold", '0);
    end

    // Basic add: the release is on a falling edge. The result must not appear
    // before the next rising edge.
    @(negedge CLK);
    CLR_N = 1'b1;
    A = 4'd3;
    B = 4'd4;
    C = 1'b0;
    exp_q.push_back(model(3, 4, 0));
    #2;
    check_out("basic_before_edge", '0);
    tick_and_score("basic_3p4");

    // Max with carry, then wrap to zero.
    drive(15, 15, 1);
    tick_and_score("max_15p15p1");
    drive(15, 0, 1);
    tick_and_score("wrap_15p0p1");
    drive(0, 0, 0);
    tick_and_score("zero");

    // Ripple path: all propagate, then inject the carry-in.
    drive(15, 0, 0);
    tick_and_score("ripple_c0");
    drive(15, 0, 1);
    tick_and_score("ripple_c1");

    // Inputs changing between edges leave the outputs unchanged.
    @(negedge CLK);
    A = 4'd1;
    B = 4'd1;
    C = 1'b0;
    #1;
    check_out("between_edges", model(15, 0, 1));
    A = 4'd2;
    B = 4'd5;
    C = 1'b1;
    exp_q.push_back(model(2, 5, 1));
    tick_and_score("late_change");

    // Exhaustive sweep of {A,B,C}.
    for (int k = 0; k < 512; k++) begin
      v = k[8:0];
      drive(int'(v[8:5]), int'(v[4:1]), int'(v[0]));
      tick_and_score($sformatf("exh_%0d", k));
    end

    // Randomized vectors.
    for (int k = 0; k < 200; k++) begin
      ra = $urandom_range(15, 0);
      rb = $urandom_range(15, 0);
      rc = $urandom_range(1, 0);
      drive(ra, rb, rc);
      tick_and_score($sformatf("rand_%0d_%0d_%0d", ra, rb, rc));
    end

    // Mid-operation reset: 9+8+1 = 18 -> SUM=2, CARRY=1.
    drive(9, 8, 1);
    tick_and_score("stream_a");
    drive(9, 8, 1);
    tick_and_score("stream_b");
    #2;
    CLR_N = 1'b0;
    #1;
    check_out("async_clear", '0);
    @(negedge CLK);
    CLR_N = 1'b1;
    #1;
    check_out("after_release_before_edge", '0);
    exp_q.push_back(model(9, 8, 1));
    tick_and_score("first_after_release");

    // Nothing should be left waiting in the scoreboard.
    check("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
